// File: rtl/gray_frame_loader.sv
// gray_frame_loader
//
// Upstream stage of the adaptive-thresholding pipeline. Accepts a byte stream
// of RGB888 pixels (R, G, B order, raster order) over a valid/ready handshake,
// converts each pixel to 8-bit luma Y = (77*R + 150*G + 29*B) >> 8 and writes
// it into the grayscale image memory read later by the box filter. `loaded`
// rises once the last pixel of the frame has been written and stays high
// until the next `start` or `reset`.
//
// Ports
//   clock        in   single clock, all logic on the rising edge
//   reset        in   synchronous, active-high
//   start        in   single-cycle pulse that begins loading a frame
//   iByte        in   stream byte
//   iByteValid   in   iByte is valid
//   iSof         in   start-of-frame marker, qualified by the byte handshake
//   oByteReady   out  loader accepts a byte this cycle (LOADING only)
//   oImageCol    out  image memory write column
//   oImageRow    out  image memory write row
//   oImageData   out  luma value to write
//   oImageWren   out  one-cycle write strobe per completed pixel
//   oLoading     out  a frame load is in progress
//   loaded       out  frame complete; sticky
module gray_frame_loader #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS,
    parameter int START_POS   = 0,
    parameter int END_POS     = WIDTH*HEIGHT-1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             iByte,
    input  logic                   iByteValid,
    input  logic                   iSof,
    output logic                   oByteReady,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    output logic [7:0]             oImageData,
    output logic                   oImageWren,
    output logic                   oLoading,
    output logic                   loaded
);

    localparam int POS_W = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);
    localparam logic [POS_W-1:0] END_P   = POS_W'(END_POS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [1:0]              phase_reg;
    logic [POS_W-1:0]        pos_reg;
    logic [7:0]              r_reg;
    logic [7:0]              g_reg;
    logic                    ready_reg;
    logic                    wren_reg;
    logic [7:0]              data_reg;
    logic [WIDTH_BITS-1:0]   col_reg;
    logic [HEIGHT_BITS-1:0]  row_reg;
    logic                    loading_reg;
    logic                    loaded_reg;

    logic                    accept;
    logic [15:0]             luma_sum;

    assign accept = iByteValid && ready_reg;

    // Operands zero-extended to 16 bits; the largest possible sum is
    // 255*256 = 65280, so the 16-bit sum never overflows.
    always_comb begin
        luma_sum = 16'd77  * {8'd0, r_reg}
                 + 16'd150 * {8'd0, g_reg}
                 + 16'd29  * {8'd0, iByte};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            phase_reg   <= 2'd0;
            pos_reg     <= START_P;
            r_reg       <= 8'd0;
            g_reg       <= 8'd0;
            ready_reg   <= 1'b0;
            wren_reg    <= 1'b0;
            data_reg    <= 8'd0;
            col_reg     <= '0;
            row_reg     <= '0;
            loading_reg <= 1'b0;
            loaded_reg  <= 1'b0;
        end else begin
            wren_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    // `loaded`/`oLoading` follow the DONE state one cycle
                    // later, so the final write pulse still sees oLoading=1.
                    if (state_reg == DONE) begin
                        loading_reg <= 1'b0;
                        loaded_reg  <= 1'b1;
                    end
                    if (start) begin
                        state_reg   <= LOADING;
                        ready_reg   <= 1'b1;
                        loading_reg <= 1'b1;
                        loaded_reg  <= 1'b0;
                        pos_reg     <= START_P;
                        phase_reg   <= 2'd0;
                    end
                end
                LOADING: begin
                    if (accept) begin
                        if (iSof) begin
                            // Resync: this byte is R of the first pixel, any
                            // partially collected pixel is dropped.
                            r_reg     <= iByte;
                            phase_reg <= 2'd1;
                            pos_reg   <= START_P;
                        end else begin
                            case (phase_reg)
                                2'd0: begin
                                    r_reg     <= iByte;
                                    phase_reg <= 2'd1;
                                end
                                2'd1: begin
                                    g_reg     <= iByte;
                                    phase_reg <= 2'd2;
                                end
                                default: begin
                                    data_reg  <= luma_sum[15:8];
                                    col_reg   <= pos_reg[WIDTH_BITS-1:0];
                                    row_reg   <= pos_reg[POS_W-1:WIDTH_BITS];
                                    wren_reg  <= 1'b1;
                                    phase_reg <= 2'd0;
                                    if (pos_reg == END_P) begin
                                        // Last pixel: stop accepting, keep pos.
                                        state_reg <= DONE;
                                        ready_reg <= 1'b0;
                                    end else begin
                                        pos_reg <= pos_reg + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign oByteReady = ready_reg;
    assign oImageWren = wren_reg;
    assign oImageData = data_reg;
    assign oImageCol  = col_reg;
    assign oImageRow  = row_reg;
    assign oLoading   = loading_reg;
    assign loaded     = loaded_reg;

endmodule

// File: tb/tb_gray_frame_loader.sv
// Testbench for gray_frame_loader on a 4x4 image. Stimulus pushes the expected
// write (data, column, row, spacing from the previous write) into a queue; an
// independent monitor pops and compares on every write pulse.
module tb_gray_frame_loader;

    localparam int WB = 2;
    localparam int HB = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    iByte = 8'd0;
    logic          iByteValid = 1'b0;
    logic          iSof = 1'b0;
    logic          oByteReady;
    logic [WB-1:0] oImageCol;
    logic [HB-1:0] oImageRow;
    logic [7:0]    oImageData;
    logic          oImageWren;
    logic          oLoading;
    logic          loaded;

    typedef struct {
        logic [7:0] data;
        int         col;
        int         row;
        int         gap;   // required cycles since previous write, 0 = any
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_wr = -1000;

    gray_frame_loader #(
        .WIDTH_BITS  (WB),
        .HEIGHT_BITS (HB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .iByte      (iByte),
        .iByteValid (iByteValid),
        .iSof       (iSof),
        .oByteReady (oByteReady),
        .oImageCol  (oImageCol),
        .oImageRow  (oImageRow),
        .oImageData (oImageData),
        .oImageWren (oImageWren),
        .oLoading   (oLoading),
        .loaded     (loaded)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clock) begin : monitor
        exp_t e;
        if (oImageWren === 1'b1) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got data=%0d col=%0d row=%0d required no write",
                         oImageData, oImageCol, oImageRow);
            end else begin
                e = sbq.pop_front();
                if (oImageData !== e.data || int'(oImageCol) != e.col ||
                    int'(oImageRow) != e.row ||
                    (e.gap != 0 && (cyc - last_wr) != e.gap)) begin
                    fails++;
                    $display("FAIL write got data=%0d col=%0d row=%0d gap=%0d required data=%0d col=%0d row=%0d gap=%0d",
                             oImageData, oImageCol, oImageRow, cyc - last_wr,
                             e.data, e.col, e.row, e.gap);
                end else begin
                    $display("[TB] write data=%0d col=%0d row=%0d gap=%0d ok",
                             oImageData, oImageCol, oImageRow, cyc - last_wr);
                end
            end
            last_wr = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end else begin
            $display("[TB] %s = %0d ok", name, act);
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        int n;
        n = 0;
        iByte = b;
        iByteValid = 1'b1;
        iSof = sof;
        @(negedge clock);
        while (!oByteReady && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!oByteReady) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout got ready=0 required ready=1 within 50 cycles");
        end
        tick();
        iByteValid = 1'b0;
        iSof = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic [7:0] y, input int col, input int row,
                              input int gap, input bit toggle, input bit lead_idle);
        exp_t e;
        if (lead_idle) tick();
        send_byte(r, 1'b0);
        if (toggle) tick();
        send_byte(g, 1'b0);
        if (toggle) tick();
        e.data = y; e.col = col; e.row = row; e.gap = gap;
        sbq.push_back(e);
        send_byte(b, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        iByteValid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_frame(input bit toggle);
        for (int p = 0; p < 16; p++) begin
            send_pixel(8'd255, 8'd255, 8'd255, 8'd255, p % 4, p / 4,
                       (p == 0) ? 0 : (toggle ? 6 : 3), toggle, toggle && p != 0);
        end
        // Cycle N+1 after the last B byte: final write, ready already low
        @(negedge clock);
        check("last_wren", oImageWren, 1);
        check("last_ready", oByteReady, 0);
        check("last_loaded_n1", loaded, 0);
        check("last_loading_n1", oLoading, 1);
        @(negedge clock);
        check("loaded_n2", loaded, 1);
        check("loading_n2", oLoading, 0);
        check("ready_n2", oByteReady, 0);
        tick();
        iByteValid = 1'b1;   // held byte must not be taken in DONE
        repeat (3) tick();
        @(negedge clock);
        check("loaded_held", loaded, 1);
        check("ready_done", oByteReady, 0);
        iByteValid = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with valid held high
        #1;
        reset = 1'b1;
        iByteValid = 1'b1;
        iByte = 8'hAA;
        tick();
        @(negedge clock);
        check("rst_ready", oByteReady, 0);
        check("rst_wren", oImageWren, 0);
        check("rst_data", oImageData, 0);
        check("rst_col", oImageCol, 0);
        check("rst_row", oImageRow, 0);
        check("rst_loading", oLoading, 0);
        check("rst_loaded", loaded, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("idle_ready", oByteReady, 0);
        tick();
        iByteValid = 1'b0;

        // start latency and single pixel (100,50,200) -> 82 at (0,0)
        pulse_start();
        @(negedge clock);
        check("start_loading", oLoading, 1);
        check("start_ready", oByteReady, 1);
        tick();
        send_pixel(8'd100, 8'd50, 8'd200, 8'd82, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("single_wren", oImageWren, 1);
        tick();
        @(negedge clock);
        check("single_wren_low", oImageWren, 0);
        tick();
        do_reset();

        // Full frame, back-to-back bytes
        pulse_start();
        run_frame(1'b0);

        // Restart from DONE, frame with valid toggling
        pulse_start();
        @(negedge clock);
        check("restart_loaded", loaded, 0);
        check("restart_loading", oLoading, 1);
        tick();
        run_frame(1'b1);

        // Resync: two pixels, partial R,G, then SOF on the B slot
        do_reset();
        pulse_start();
        send_pixel(8'd100, 8'd50, 8'd200, 8'd82, 0, 0, 0, 1'b0, 1'b0);
        send_pixel(8'd10, 8'd20, 8'd30, 8'd18, 1, 0, 3, 1'b0, 1'b0);
        send_byte(8'd77, 1'b0);
        send_byte(8'd88, 1'b0);
        send_byte(8'd0, 1'b1);
        send_byte(8'd0, 1'b0);
        begin
            exp_t e;
            e.data = 8'd0; e.col = 0; e.row = 0; e.gap = 5;
            sbq.push_back(e);
        end
        send_byte(8'd0, 1'b0);
        send_pixel(8'd255, 8'd255, 8'd255, 8'd255, 1, 0, 3, 1'b0, 1'b0);
        send_pixel(8'd0, 8'd0, 8'd0, 8'd0, 2, 0, 3, 1'b0, 1'b0);
        tick();

        // Reset mid-frame after 5 pixels
        do_reset();
        pulse_start();
        for (int p = 0; p < 5; p++)
            send_pixel(8'd255, 8'd255, 8'd255, 8'd255, p % 4, p / 4,
                       (p == 0) ? 0 : 3, 1'b0, 1'b0);
        send_byte(8'd12, 1'b0);
        iByteValid = 1'b1;
        iByte = 8'd34;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("midrst_wren", oImageWren, 0);
            tick();
        end
        check("midrst_loaded", loaded, 0);
        check("midrst_ready", oByteReady, 0);
        iByteValid = 1'b0;
        pulse_start();
        send_pixel(8'd100, 8'd50, 8'd200, 8'd82, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();

        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gray_frame_loader.md
# gray_frame_loader

Upstream stage of the adaptive-thresholding pipeline. Accepts a byte stream of RGB888 pixels (R, G, B order, raster order) over a valid/ready handshake and converts each pixel to 8-bit luma. Writes each luma value into the grayscale image memory that the box filter later reads. Raises `loaded` once the last pixel of the frame is written; `loaded` drives the box filter's `processing` input.

## Interface
- `WIDTH_BITS`, 8, column address width
- `HEIGHT_BITS`, 8, row address width
- `WIDTH`, 2**WIDTH_BITS, image width in pixels
- `HEIGHT`, 2**HEIGHT_BITS, image height in pixels
- `START_POS`, 0, linear position of the first pixel written
- `END_POS`, WIDTH*HEIGHT-1, linear position of the last pixel written
- `clock`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle pulse that begins loading a frame
- `iByte`  in  8  stream byte
- `iByteValid`  in  1  `iByte` is valid
- `iSof`  in  1  start-of-frame marker; qualified by `iByteValid`
- `oByteReady`  out  1  loader accepts a byte this cycle
- `oImageCol`  out  WIDTH_BITS  image memory write column
- `oImageRow`  out  HEIGHT_BITS  image memory write row
- `oImageData`  out  8  luma value to write
- `oImageWren`  out  1  image memory write enable; one-cycle pulse per pixel
- `oLoading`  out  1  a frame load is in progress
- `loaded`  out  1  frame complete; sticky

## Operation
- **States**
  - IDLE: reset state.
  - LOADING: receiving bytes.
  - DONE: frame written; `loaded`=1.
- **Transitions**
  - IDLE --`start`--> LOADING
  - DONE --`start`--> LOADING
  - `start` in LOADING is ignored.
  - LOADING --write of `END_POS`--> DONE
- **Entering LOADING:** `pos`<=START_POS, `phase`<=0, `loaded`<=0.
- **Handshake:**
  - `oByteReady`=1 only in LOADING.
  - A byte is accepted when `iByteValid`&&`oByteReady`.
  - `iByte` and `iSof` are ignored when the byte is not accepted.
- **Byte phase** (2-bit counter, 0=R, 1=G, 2=B):
  - Phases 0 and 1 latch R and G.
  - Phase 2 computes luma from the latched R, G and the current `iByte`, then wraps `phase` to 0.
- **Start-of-frame resync:** an accepted byte with `iSof`=1 is treated as R.
  - `phase` is forced to 1.
  - `pos` is forced to START_POS.
  - Any partial pixel is discarded.
- **Luma:** Y = (77*R + 150*G + 29*B) >> 8.
  - Products are computed unsigned in 16 bits; max sum is 65280, so no overflow.
  - Result is bits [15:8]. (255,255,255) maps to 255; (0,0,0) maps to 0.
- **Write address:** `oImageCol`=pos[WIDTH_BITS-1:0], `oImageRow`=pos[WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS]. `pos` is the linear position of the pixel being written.
- **After each pixel:** `pos` increments. When the pixel at END_POS is written, `pos` does not wrap and the state goes to DONE.
- **Bytes in IDLE or DONE:** not accepted (ready low); the upstream source must hold them.

## Timing
- **Reset values** (the cycle after `reset` is sampled high):
  - `oByteReady`=0, `oImageWren`=0, `oImageData`=0, `oImageCol`=0, `oImageRow`=0, `oLoading`=0, `loaded`=0
  - state=IDLE, `phase`=0, `pos`=START_POS
- **`reset` priority:** `reset` overrides `start` and byte acceptance in the same cycle. Reset mid-frame abandons the frame with no further write pulse.
- **`start` latency:** `start` sampled in cycle N gives `oLoading`=1 and `oByteReady`=1 in cycle N+1.
- **Write latency:**
  - Phase-2 byte accepted in cycle N: `oImageWren`=1 in cycle N+1, with registered `oImageData`/`oImageCol`/`oImageRow` valid in that cycle.
  - `oImageWren` returns to 0 in cycle N+2 unless another pixel completes.
- **Throughput:** one byte per cycle; back-to-back pixels give a write pulse every 3 cycles.
- **Last pixel:**
  - `oByteReady` drops in cycle N+1, the same cycle as the final write pulse.
  - `loaded`=1 and `oLoading`=0 from cycle N+2, held until `start` or `reset`.
- **`iSof` on a phase-2 position:** resync wins; no write is produced for that pixel.

## Test plan
- Reset: assert `reset` 2 cycles with `iByteValid`=1 → every output is 0; `oByteReady` stays 0 until `start`.
- Single pixel, WIDTH_BITS=HEIGHT_BITS=2: `start`, then bytes 100, 50, 200 on consecutive cycles → one `oImageWren` pulse 1 cycle after the B byte, `oImageData`=82 (21000>>8), col=0, row=0.
- Full 4x4 frame of (255,255,255), valid held high: 48 bytes → 16 write pulses every 3 cycles; data=255; addresses (0,0)…(3,3) in raster order; `loaded`=1 two cycles after the last B byte; `oByteReady`=0 afterwards.
- Same frame with `iByteValid` toggling 1/0 → identical data and addresses, pulses spaced 6 cycles; no byte is lost or duplicated.
- Resync: send R, G of a pixel, then a byte with `iSof`=1 followed by 3 more pixels of (0,0,0) → first write lands at (0,0) with data 0; the partial pixel never produces a write.
- Reset mid-frame after 5 pixels → no further `oImageWren`; `loaded`=0; a new `start` restarts writing at (0,0).
